// File: rtl/sw_result_collector_pkg.sv
// Shared widths and record layout for the SmithWaterman result collector.
// Optional feature macro: SW_HIT_COUNT_EN (per-query hit counter stored in each record).
`ifndef SW_RESULT_COLLECTOR_PKG_SV
`define SW_RESULT_COLLECTOR_PKG_SV

`ifndef CALC_BIT
`define CALC_BIT 16
`endif

`ifndef MAX_T_NUM_BIT
`define MAX_T_NUM_BIT 10
`endif

`ifndef SW_REC_Q_BIT
`define SW_REC_Q_BIT 8
`endif

// Record field order, MSB first: q_idx, match_idx, max_result, cnt, [hits]
`ifdef SW_HIT_COUNT_EN
`define SW_REC_HITS_W (`MAX_T_NUM_BIT + 1)
`else
`define SW_REC_HITS_W 0
`endif

`define SW_REC_W (`SW_REC_Q_BIT + `MAX_T_NUM_BIT + `CALC_BIT + (`MAX_T_NUM_BIT + 1) + `SW_REC_HITS_W)

package sw_result_collector_pkg;

   localparam int unsigned CALC_W     = `CALC_BIT;
   localparam int unsigned T_W        = `MAX_T_NUM_BIT;
   localparam int unsigned SW_REC_Q_W = `SW_REC_Q_BIT;

   // Packed record width for a given query-index and count width
   function automatic int unsigned rec_width(input int unsigned q_w,
                                             input int unsigned cnt_w,
                                             input bit          hits_en);
      return q_w + T_W + CALC_W + cnt_w + (hits_en ? cnt_w : 0);
   endfunction

endpackage

`endif

// File: rtl/sw_result_collector_if.sv
// Valid/ready record stream: master produces records, slave accepts them.
interface sw_result_collector_if #(
   parameter int unsigned WIDTH = 1
) ();

   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/sw_rec_fifo.sv
// Synchronous record FIFO with registered storage and a combinational head.
// Push while full is accepted only if the head is popped in the same cycle.
module sw_rec_fifo
   import sw_result_collector_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   sw_result_collector_if.slave     push_if,
   sw_result_collector_if.master    pop_if,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W:0]   level_q, level_d;
   logic             full, empty;
   logic             do_push, do_pop;

   assign full    = (level_q == (PTR_W+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_pop  = !empty && pop_if.ready;
   assign push_if.ready = !full || do_pop;
   assign do_push = push_if.valid && push_if.ready;

   assign pop_if.valid = !empty;
   assign pop_if.data  = empty ? '0 : mem_q[rd_q];
   assign level_o      = level_q;

   // Pointer and occupancy next state; clear wins over push/pop
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      level_d = level_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      if (clear_i) begin
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

   // Storage write; entries are never read while empty so they need no reset
   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_q] <= push_if.data;
   end

endmodule

// File: rtl/sw_result_collector.sv
// SmithWaterman result collector: per-query target count, own best score/index,
// cross-check against the upstream max, and a summary-record FIFO for the host.
// Optional feature macro: SW_HIT_COUNT_EN (count targets with result_i >= thresh_i).
module sw_result_collector
   import sw_result_collector_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned Q_IDX_BIT = SW_REC_Q_W,
   parameter int unsigned CNT_BIT   = T_W + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear_i,
   input  logic                   valid_i,
   input  logic [CALC_W-1:0]      result_i,
   input  logic                   change_q_i,
   input  logic [T_W-1:0]         match_idx_i,
   input  logic [CALC_W-1:0]      max_result_i,
   input  logic [CALC_W-1:0]      thresh_i,
   output logic                   rec_valid_o,
   input  logic                   rec_ready_i,
   output logic [Q_IDX_BIT-1:0]   rec_q_idx_o,
   output logic [T_W-1:0]         rec_idx_o,
   output logic [CALC_W-1:0]      rec_max_o,
   output logic [CNT_BIT-1:0]     rec_cnt_o,
   output logic [CNT_BIT-1:0]     rec_hits_o,
   output logic                   mismatch_o,
   output logic                   overflow_o,
   output logic [$clog2(DEPTH):0] level_o
);

`ifdef SW_HIT_COUNT_EN
   localparam bit HITS_EN = 1'b1;
`else
   localparam bit HITS_EN = 1'b0;
`endif

   localparam int unsigned REC_W = rec_width(Q_IDX_BIT, CNT_BIT, HITS_EN);

   logic [Q_IDX_BIT-1:0] q_idx_q, q_idx_d;
   logic [CNT_BIT-1:0]   cnt_q, cnt_d, cnt_next;
   logic [CALC_W-1:0]    best_q, best_d, best_next;
   logic [T_W-1:0]       idx_q, idx_d, idx_next;
   logic                 mismatch_q, mismatch_d;
   logic                 overflow_q, overflow_d;
   logic                 take;

`ifdef SW_HIT_COUNT_EN
   logic [CNT_BIT-1:0]   hits_q, hits_d, hits_next;
`else
   logic                 unused_thresh;
   assign unused_thresh = ^thresh_i;
`endif

   sw_result_collector_if #(.WIDTH(REC_W)) push_if ();
   sw_result_collector_if #(.WIDTH(REC_W)) pop_if ();

   sw_rec_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear_i),
      .push_if (push_if),
      .pop_if  (pop_if),
      .level_o (level_o)
   );

   // Running values including the current target (the last target is folded in before the push)
   always_comb begin
      cnt_next  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      take      = (cnt_q == '0) || (result_i > best_q);
      best_next = take ? result_i : best_q;
      idx_next  = take ? T_W'(cnt_q) : idx_q;
`ifdef SW_HIT_COUNT_EN
      hits_next = ((result_i >= thresh_i) && (hits_q != '1)) ? hits_q + 1'b1 : hits_q;
`endif
   end

   // Record push toward the FIFO; a clear in the same cycle discards it
   assign push_if.valid = valid_i && change_q_i && !clear_i;
`ifdef SW_HIT_COUNT_EN
   assign push_if.data  = {q_idx_q, match_idx_i, max_result_i, cnt_next, hits_next};
`else
   assign push_if.data  = {q_idx_q, match_idx_i, max_result_i, cnt_next};
`endif

   // Host side of the FIFO
   assign pop_if.ready = rec_ready_i;
   assign rec_valid_o  = pop_if.valid;
`ifdef SW_HIT_COUNT_EN
   assign {rec_q_idx_o, rec_idx_o, rec_max_o, rec_cnt_o, rec_hits_o} = pop_if.data;
`else
   assign {rec_q_idx_o, rec_idx_o, rec_max_o, rec_cnt_o} = pop_if.data;
   assign rec_hits_o = '0;
`endif

   assign mismatch_o = mismatch_q;
   assign overflow_o = overflow_q;

   // Per-query accumulation, cross-check and sticky flags
   always_comb begin
      q_idx_d    = q_idx_q;
      cnt_d      = cnt_q;
      best_d     = best_q;
      idx_d      = idx_q;
      mismatch_d = mismatch_q;
      overflow_d = overflow_q;
`ifdef SW_HIT_COUNT_EN
      hits_d     = hits_q;
`endif
      if (valid_i) begin
         if (change_q_i) begin
            q_idx_d = q_idx_q + 1'b1;
            cnt_d   = '0;
            best_d  = '0;
            idx_d   = '0;
`ifdef SW_HIT_COUNT_EN
            hits_d  = '0;
`endif
            if ((best_next != max_result_i) || (idx_next != match_idx_i)) mismatch_d = 1'b1;
            // Dropped record: q_idx still advances so the host sees the gap
            if (!push_if.ready) overflow_d = 1'b1;
         end else begin
            cnt_d  = cnt_next;
            best_d = best_next;
            idx_d  = idx_next;
`ifdef SW_HIT_COUNT_EN
            hits_d = hits_next;
`endif
         end
      end
      if (clear_i) begin
         q_idx_d    = '0;
         cnt_d      = '0;
         best_d     = '0;
         idx_d      = '0;
         mismatch_d = 1'b0;
         overflow_d = 1'b0;
`ifdef SW_HIT_COUNT_EN
         hits_d     = '0;
`endif
      end
   end

   // Accumulator and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_idx_q    <= '0;
         cnt_q      <= '0;
         best_q     <= '0;
         idx_q      <= '0;
         mismatch_q <= 1'b0;
         overflow_q <= 1'b0;
`ifdef SW_HIT_COUNT_EN
         hits_q     <= '0;
`endif
      end else begin
         q_idx_q    <= q_idx_d;
         cnt_q      <= cnt_d;
         best_q     <= best_d;
         idx_q      <= idx_d;
         mismatch_q <= mismatch_d;
         overflow_q <= overflow_d;
`ifdef SW_HIT_COUNT_EN
         hits_q     <= hits_d;
`endif
      end
   end

endmodule

// File: tb/tb_sw_result_collector.sv
// Self-checking bench for sw_result_collector against a queue-based reference model.
module tb_sw_result_collector;
   import sw_result_collector_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned QW    = 8;
   localparam int unsigned CW    = T_W + 1;
   localparam int unsigned DW    = QW + T_W + CALC_W + CW;
   localparam int          CMAX  = (1 << CW) - 1;

   typedef struct {
      int q;
      int idx;
      int max;
      int cnt;
      int hits;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              valid = 1'b0;
   logic              last = 1'b0;
   logic [CALC_W-1:0] result = '0;
   logic [T_W-1:0]    midx = '0;
   logic [CALC_W-1:0] mmax = '0;
   logic [CALC_W-1:0] thresh = '0;
   logic [QW-1:0]     rec_q_idx;
   logic [T_W-1:0]    rec_idx;
   logic [CALC_W-1:0] rec_max;
   logic [CW-1:0]     rec_cnt;
   logic [CW-1:0]     rec_hits;
   logic              mismatch, overflow;
   logic [3:0]        level;

   int n_cmp = 0;
   int n_err = 0;

   exp_t mq[$];
   int   scores[$];
   int   m_q = 0;
   bit   m_mis = 1'b0;
   bit   m_ovf = 1'b0;

   always #5 clk = ~clk;

   sw_result_collector_if #(.WIDTH(DW)) host_if ();
   assign host_if.data = {rec_q_idx, rec_idx, rec_max, rec_cnt};

   sw_result_collector #(
      .DEPTH     (DEPTH),
      .Q_IDX_BIT (QW),
      .CNT_BIT   (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clear),
      .valid_i      (valid),
      .result_i     (result),
      .change_q_i   (last),
      .match_idx_i  (midx),
      .max_result_i (mmax),
      .thresh_i     (thresh),
      .rec_valid_o  (host_if.valid),
      .rec_ready_i  (host_if.ready),
      .rec_q_idx_o  (rec_q_idx),
      .rec_idx_o    (rec_idx),
      .rec_max_o    (rec_max),
      .rec_cnt_o    (rec_cnt),
      .rec_hits_o   (rec_hits),
      .mismatch_o   (mismatch),
      .overflow_o   (overflow),
      .level_o      (level)
   );

   function automatic logic [DW-1:0] pack(input exp_t r);
      return {QW'(r.q), T_W'(r.idx), CALC_W'(r.max), CW'(r.cnt)};
   endfunction

   function automatic void model_flush();
      mq.delete();
      scores.delete();
      m_q   = 0;
      m_mis = 1'b0;
      m_ovf = 1'b0;
   endfunction

   // Applies the current inputs to the model, then advances one clock and settles
   task automatic step();
      exp_t r;
      int   best, bi, h;
      bit   pop;
      pop = host_if.ready && (mq.size() > 0);
      if (clear) begin
         model_flush();
      end else begin
         if (pop) void'(mq.pop_front());
         if (valid) begin
            scores.push_back(int'(result));
            if (last) begin
               best = -1; bi = 0; h = 0;
               foreach (scores[i]) begin
                  if (scores[i] > best) begin best = scores[i]; bi = i; end
                  if (scores[i] >= int'(thresh)) h++;
               end
               r.q    = m_q;
               r.idx  = int'(midx);
               r.max  = int'(mmax);
               r.cnt  = (scores.size() > CMAX) ? CMAX : scores.size();
`ifdef SW_HIT_COUNT_EN
               r.hits = (h > CMAX) ? CMAX : h;
`else
               r.hits = 0;
`endif
               if ((best != int'(mmax)) || (bi != int'(midx))) m_mis = 1'b1;
               if (mq.size() < DEPTH) mq.push_back(r);
               else m_ovf = 1'b1;
               m_q = (m_q + 1) % (1 << QW);
               scores.delete();
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int score, input bit l, input int ui, input int um);
      valid  = 1'b1;
      last   = l;
      result = CALC_W'(score);
      midx   = T_W'(ui);
      mmax   = CALC_W'(um);
      step();
      valid  = 1'b0;
      last   = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (host_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", host_if.valid); end
      n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
      n_cmp++; if ({host_if.data, rec_hits} !== '0) begin n_err++; $display("FAIL reset_fields got %0h want 0", {host_if.data, rec_hits}); end
      n_cmp++; if ({mismatch, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %0b want 00", {mismatch, overflow}); end
      @(negedge clk);
      rst_n = 1'b1;
      model_flush();
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      host_if.ready = 1'b1;
      send(5, 0, 1, 12);
      send(12, 0, 1, 12);
      send(12, 0, 1, 12);
      send(3, 1, 1, 12);
      n_cmp++; if (host_if.valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b want 1", host_if.valid); end
      n_cmp++; if ({rec_q_idx, rec_idx, rec_max, rec_cnt} !== {8'd0, 10'd1, 16'd12, 11'd4})
         begin n_err++; $display("FAIL basic_record got q=%0d idx=%0d max=%0d cnt=%0d want q=0 idx=1 max=12 cnt=4", rec_q_idx, rec_idx, rec_max, rec_cnt); end
      n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL basic_mismatch got %0b want 0", mismatch); end
      step();
      n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL basic_drained got %0d want 0", level); end
   endtask

   task automatic test_mismatch();
      host_if.ready = 1'b1;
      send(5, 0, 2, 12);
      send(12, 0, 2, 12);
      send(12, 0, 2, 12);
      send(3, 1, 2, 12);
      n_cmp++; if ({rec_q_idx, rec_idx, rec_max, rec_cnt} !== {8'd1, 10'd2, 16'd12, 11'd4})
         begin n_err++; $display("FAIL mis_record got q=%0d idx=%0d max=%0d cnt=%0d want q=1 idx=2 max=12 cnt=4", rec_q_idx, rec_idx, rec_max, rec_cnt); end
      n_cmp++; if (mismatch !== 1'b1) begin n_err++; $display("FAIL mis_set got %0b want 1", mismatch); end
      repeat (5) step();
      n_cmp++; if (mismatch !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %0b want 1", mismatch); end
      do_clear();
      n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL mis_clear got %0b want 0", mismatch); end
   endtask

   task automatic test_overflow();
      host_if.ready = 1'b0;
      for (int i = 0; i < 9; i++) send(20 + i, 1, 0, 20 + i);
      n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", level); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", overflow); end
      host_if.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (rec_q_idx !== QW'(i)) begin n_err++; $display("FAIL ovf_drain_q got %0d want %0d", rec_q_idx, i); end
         n_cmp++; if (host_if.data !== pack(mq[0])) begin n_err++; $display("FAIL ovf_drain_rec got %0h want %0h", host_if.data, pack(mq[0])); end
         step();
      end
      host_if.ready = 1'b0;
      send(7, 1, 0, 7);
      n_cmp++; if (rec_q_idx !== 8'd9) begin n_err++; $display("FAIL ovf_gap_q got %0d want 9", rec_q_idx); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
      do_clear();
      n_cmp++; if ({overflow, level} !== 5'd0) begin n_err++; $display("FAIL ovf_clear got %0h want 0", {overflow, level}); end
   endtask

   task automatic test_full_push_pop();
      host_if.ready = 1'b0;
      for (int i = 0; i < 8; i++) send(i, 1, 0, i);
      host_if.ready = 1'b1;
      send(100, 1, 0, 100);
      n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL fpp_level got %0d want 8", level); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow got %0b want 0", overflow); end
      n_cmp++; if (rec_q_idx !== 8'd1) begin n_err++; $display("FAIL fpp_head got %0d want 1", rec_q_idx); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (host_if.data !== pack(mq[0])) begin n_err++; $display("FAIL fpp_drain got %0h want %0h", host_if.data, pack(mq[0])); end
         step();
      end
      n_cmp++; if (host_if.valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty got %0b want 0", host_if.valid); end
      do_clear();
   endtask

   task automatic test_hits();
      logic [CW-1:0] want;
`ifdef SW_HIT_COUNT_EN
      want = CW'(2);
`else
      want = '0;
`endif
      host_if.ready = 1'b0;
      thresh = CALC_W'(10);
      send(9, 0, 2, 11);
      send(10, 0, 2, 11);
      send(11, 1, 2, 11);
      n_cmp++; if (rec_hits !== want) begin n_err++; $display("FAIL hits got %0d want %0d", rec_hits, want); end
      n_cmp++; if (host_if.data !== {8'd0, 10'd2, 16'd11, 11'd3}) begin n_err++; $display("FAIL hits_record got %0h", host_if.data); end
      do_clear();
   endtask

   task automatic test_saturate();
      host_if.ready = 1'b0;
      for (int i = 0; i < CMAX + 2; i++) send(1, 0, 0, 1);
      send(1, 1, 0, 1);
      n_cmp++; if (rec_cnt !== CW'(CMAX)) begin n_err++; $display("FAIL sat_cnt got %0d want %0d", rec_cnt, CMAX); end
      n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL sat_mismatch got %0b want 0", mismatch); end
      do_clear();
   endtask

   task automatic test_random();
      int tmp[$];
      int best, bi;
      for (int c = 0; c < 600; c++) begin
         host_if.ready = ($urandom_range(0, 2) == 0);
         clear  = ($urandom_range(0, 63) == 0);
         valid  = ($urandom_range(0, 1) == 1);
         last   = valid && ($urandom_range(0, 3) == 0);
         result = CALC_W'($urandom_range(0, 31));
         thresh = CALC_W'($urandom_range(0, 31));
         tmp = scores;
         tmp.push_back(int'(result));
         best = -1; bi = 0;
         foreach (tmp[i]) if (tmp[i] > best) begin best = tmp[i]; bi = i; end
         midx = T_W'(bi);
         mmax = CALC_W'(($urandom_range(0, 7) == 0) ? best + 1 : best);
         step();
         clear = 1'b0; valid = 1'b0; last = 1'b0;
         n_cmp++; if (host_if.valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, host_if.valid, mq.size() > 0); end
         n_cmp++; if (level !== 4'(mq.size())) begin n_err++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, mq.size()); end
         if (mq.size() > 0) begin
            n_cmp++; if (host_if.data !== pack(mq[0])) begin n_err++; $display("FAIL rnd_rec c=%0d got %0h want %0h", c, host_if.data, pack(mq[0])); end
            n_cmp++; if (rec_hits !== CW'(mq[0].hits)) begin n_err++; $display("FAIL rnd_hits c=%0d got %0d want %0d", c, rec_hits, mq[0].hits); end
         end
         n_cmp++; if ({mismatch, overflow} !== {m_mis, m_ovf}) begin n_err++; $display("FAIL rnd_flags c=%0d got %0b want %0b", c, {mismatch, overflow}, {m_mis, m_ovf}); end
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      host_if.ready = 1'b0;
      for (int i = 0; i < 3; i++) send(i, 1, 0, i);
      send(4, 0, 0, 0);
      send(6, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_flush();
      n_cmp++; if (host_if.valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %0b want 0", host_if.valid); end
      n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL arst_level got %0d want 0", level); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(7, 1, 0, 7);
      n_cmp++; if ({rec_q_idx, rec_cnt} !== {8'd0, 11'd1}) begin n_err++; $display("FAIL arst_next got q=%0d cnt=%0d want q=0 cnt=1", rec_q_idx, rec_cnt); end
      n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL arst_mismatch got %0b want 0", mismatch); end
   endtask

   initial begin
      host_if.ready = 1'b0;
      test_reset();
      test_basic();
      test_mismatch();
      test_overflow();
      test_full_push_pop();
      test_hits();
      test_saturate();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
